// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter granting one of NUM_REQ byte sources
// to a single UART transmitter, with burst limit, release gap and stall timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);
  localparam int LW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1) > 0 ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1) > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
  state_e          state_q, state_d;
  logic [LW-1:0]   last_q, last_d, pick;
  logic [BW-1:0]   burst_q, burst_d;
  logic [TW-1:0]   to_q, to_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            tout_q, tout_d;
  logic            send, vg, lg, xfer, rel;
  logic [7:0]      dg;
  logic [NUM_REQ-1:0] oh;
  // Search downward so the smallest offset after last_q wins.
  always_comb begin
    pick = last_q;
    vg = 1'b0;
    lg = 1'b0;
    dg = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid_i[(int'(last_q) + k) % NUM_REQ]) pick = LW'((int'(last_q) + k) % NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++)
      if (LW'(i) == last_q) begin
        vg = req_valid_i[i];
        lg = req_last_i[i];
        dg = req_data_i[8*i +: 8];
      end
  end
  // Reset masks the outputs in its own cycle so an in-flight burst stops at once.
  assign send        = state_q == SEND && !reset;
  assign oh          = NUM_REQ'(1) << last_q;
  assign xfer        = send && vg && tx_ready_i;
  assign grant_o     = send ? oh : '0;
  assign req_ready_o = xfer ? oh : '0;
  assign tx_valid_o  = send && vg;
  assign tx_data_o   = send ? dg : '0;
  assign busy_o      = state_q != IDLE && !reset;
  assign timeout_o   = tout_q && !reset;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    to_d    = to_q;
    gap_d   = gap_q;
    tout_d  = 1'b0;
    rel     = 1'b0;
    if (state_q == IDLE) begin
      if (|req_valid_i) begin
        state_d = SEND;
        last_d  = pick;
        burst_d = '0;
        to_d    = '0;
      end
    end else if (state_q == SEND) begin
      if (xfer) begin
        burst_d = burst_q + 1'b1;
        to_d    = '0;
        rel     = lg || burst_q == BW'(MAX_BURST - 1);
      end else begin
        to_d   = to_q + 1'b1;
        tout_d = to_q == TW'(TIMEOUT - 1);
        rel    = tout_d;
      end
      if (rel) begin
        state_d = GAP_CYCLES == 0 ? IDLE : GAP;
        gap_d   = '0;
      end
    end else begin
      gap_d   = gap_q + 1'b1;
      state_d = gap_q == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LW'(NUM_REQ - 1);
      burst_q <= '0;
      to_q    <= '0;
      gap_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      tout_q  <= tout_d;
    end
  end
endmodule
